alu_op_sequencer: RTL and testbench

//  Initiator side of the 8-bit ALU port (a, b, opcode -> result, flags).

---
 rtl/alu_op_sequencer.sv | 174 +++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: initiator side of the 8-bit ALU port.
// Accepts register-level commands, reads operands from a 4x8 register bank,
// drives the external ALU for SETTLE_CYC cycles, captures result/flags,
// writes back and returns the result over a valid/ready response channel.
// SETTLE_CYC legal range is 1..15 (4-bit settle counter).
`timescale 1ns/1ps

module alu_op_sequencer #(
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic       clk,
  input  logic       rst,
  // command channel
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [1:0] cmd_rd,
  input  logic [1:0] cmd_rs1,
  input  logic [1:0] cmd_rs2,
  input  logic [7:0] cmd_imm,
  // external ALU port
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_op,
  input  logic [7:0] alu_result,
  input  logic [3:0] alu_flags,
  // response channel
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_result,
  output logic [3:0] rsp_flags
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYC - 1);

  localparam logic [2:0] OP_CMP = 3'b101;
  localparam logic [2:0] OP_LDI = 3'b110;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       op_q;
  logic [1:0]       rd_q;
  logic             cmd_ready_q;
  logic             rsp_valid_q;
  logic [7:0]       rsp_result_q;
  logic [3:0]       flags_q;
  logic [7:0]       alu_a_q;
  logic [7:0]       alu_b_q;
  logic [2:0]       alu_op_q;

  // Register bank and its single write port.
  logic [7:0]       regs_q [4];
  logic [3:0]       wr_en_d;
  logic [7:0]       wr_data_d;
  logic             accept_d;

  assign accept_d = (state_q == IDLE) && cmd_valid && cmd_ready_q;

  // Write-port decode: load-immediate writes at accept, ALU ops (except cmp) at capture.
  always_comb begin
    wr_en_d   = 4'b0000;
    wr_data_d = 8'h00;
    if (accept_d && (cmd_op == OP_LDI)) begin
      wr_en_d[cmd_rd] = 1'b1;
      wr_data_d       = cmd_imm;
    end else if ((state_q == CAPTURE) && (op_q != OP_CMP)) begin
      wr_en_d[rd_q] = 1'b1;
      wr_data_d     = alu_result;
    end
  end

  // One register per bank entry; reset clears the whole bank.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_bank
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          regs_q[gi] <= 8'h00;
        end else if (wr_en_d[gi]) begin
          regs_q[gi] <= wr_data_d;
        end
      end
    end
  endgenerate

  // Command sequencing FSM with all channel/ALU outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      op_q         <= 3'b000;
      rd_q         <= 2'b00;
      cmd_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= 8'h00;
      flags_q      <= 4'h0;
      alu_a_q      <= 8'h00;
      alu_b_q      <= 8'h00;
      alu_op_q     <= 3'b000;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            op_q        <= cmd_op;
            rd_q        <= cmd_rd;
            cmd_ready_q <= 1'b0;
            if (cmd_op <= OP_CMP) begin
              // Operands come from the bank as it stands now (pre-write value).
              alu_a_q  <= regs_q[cmd_rs1];
              alu_b_q  <= regs_q[cmd_rs2];
              alu_op_q <= cmd_op;
              cnt_q    <= CNT_INIT;
              state_q  <= ISSUE;
            end else if (cmd_op == OP_LDI) begin
              rsp_result_q <= cmd_imm;
              rsp_valid_q  <= 1'b1;
              state_q      <= RESP;
            end else begin
              rsp_result_q <= 8'h00;
              rsp_valid_q  <= 1'b1;
              state_q      <= RESP;
            end
          end
        end

        ISSUE: begin
          // ALU inputs stay untouched while the external ALU settles.
          if (cnt_q == '0) begin
            state_q <= CAPTURE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        CAPTURE: begin
          rsp_result_q <= alu_result;
          flags_q      <= alu_flags;
          rsp_valid_q  <= 1'b1;
          state_q      <= RESP;
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end

        default: begin
          state_q     <= IDLE;
          cmd_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = flags_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer: behavioural ALU plus a register/flag
// reference model; directed scenarios followed by random commands and a
// reset-during-issue scenario.
`timescale 1ns/1ps

module tb_alu_op_sequencer;

  localparam int S = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [1:0] cmd_rd, cmd_rs1, cmd_rs2;
  logic [7:0] cmd_imm;
  logic [7:0] alu_a, alu_b, alu_result;
  logic [2:0] alu_op;
  logic [3:0] alu_flags;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_result;
  logic [3:0] rsp_flags;

  int errors = 0;
  int checks = 0;

  logic [7:0] mr [4];
  logic [3:0] mf;
  logic [7:0] last_res;
  logic [3:0] last_flags;

  always #5 clk = ~clk;

  alu_op_sequencer #(.SETTLE_CYC(S)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_imm(cmd_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags)
  );

  // Behavioural 8-bit ALU: returns {result, flags[3:0]} = {.., neg, ovf, carry, zero}.
  function automatic logic [11:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int ua = int'(a);
    int ub = int'(b);
    int sa = int'($signed(a));
    int sb = int'($signed(b));
    int r  = 0;
    int sr = 0;
    logic c = 1'b0;
    logic v = 1'b0;
    logic [7:0] res;
    case (op)
      3'd0: begin r = ua + ub; sr = sa + sb; c = (r > 255); v = (sr > 127) || (sr < -128); end
      3'd1, 3'd5: begin r = ua - ub; sr = sa - sb; c = (ua < ub); v = (sr > 127) || (sr < -128); end
      3'd2: r = int'(a & b);
      3'd3: r = int'(a | b);
      3'd4: r = int'(a ^ b);
      default: r = 0;
    endcase
    res = r[7:0];
    return {res, res[7], v, c, (res == 8'h00)};
  endfunction

  always_comb begin
    {alu_result, alu_flags} = alu_fn(alu_op, alu_a, alu_b);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one command, wait for its response, hold rsp_ready low for `hold` cycles, retire it.
  task automatic run_cmd(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                         input logic [1:0] rs2, input logic [7:0] imm, input int hold);
    logic [11:0] rf;
    logic [7:0]  er, pa, pb, a0, b0;
    logic [3:0]  ef;
    logic [2:0]  po, o0;
    int          elat, lat, w;
    bit          got, stable, held;

    if (op <= 3'd5) begin
      rf = alu_fn(op, mr[rs1], mr[rs2]);
      er = rf[11:4]; ef = rf[3:0]; elat = S + 2;
    end else if (op == 3'd6) begin
      er = imm; ef = mf; elat = 1;
    end else begin
      er = 8'h00; ef = mf; elat = 1;
    end

    @(negedge clk);
    w = 0;
    while (!cmd_ready && w < 50) begin @(negedge clk); w++; end
    check("cmd_ready_idle", cmd_ready, 1);
    pa = alu_a; pb = alu_b; po = alu_op;
    rsp_ready = (hold == 0);
    cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op = 3'($urandom); cmd_rd = 2'($urandom); cmd_rs1 = 2'($urandom);
    cmd_rs2 = 2'($urandom); cmd_imm = 8'($urandom);
    a0 = alu_a; b0 = alu_b; o0 = alu_op;
    lat = 1; got = 0; stable = 1;
    while (lat < 40) begin
      if (rsp_valid) begin got = 1; break; end
      stable &= (alu_a === a0) && (alu_b === b0) && (alu_op === o0) && (cmd_ready === 1'b0);
      @(negedge clk);
      lat++;
    end
    check("rsp_seen", got, 1);
    check("latency", lat, elat);
    check("alu_stable_busy", stable, 1);
    check("alu_op_legal", (alu_op < 3'd6), 1);
    if (op <= 3'd5) begin
      check("alu_operands", {a0, b0, 5'd0, o0}, {mr[rs1], mr[rs2], 5'd0, op});
    end else begin
      check("alu_unchanged", {alu_a, alu_b, 5'd0, alu_op}, {pa, pb, 5'd0, po});
    end
    check("rsp_result", rsp_result, er);
    check("rsp_flags", rsp_flags, ef);
    last_res = rsp_result; last_flags = rsp_flags;

    if (hold > 0) begin
      held = 1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        held &= (rsp_valid === 1'b1) && (rsp_result === er) && (rsp_flags === ef) && (cmd_ready === 1'b0);
      end
      check("rsp_hold_stable", held, 1);
      rsp_ready = 1'b1;
    end
    @(negedge clk);
    check("retire_idle", {rsp_valid, cmd_ready}, 2'b01);

    if (op <= 3'd5) begin
      mf = ef;
      if (op != 3'd5) mr[rd] = er;
    end else if (op == 3'd6) begin
      mr[rd] = imm;
    end
  endtask

  initial begin
    bit quiet;
    rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b1;
    cmd_op = 3'd0; cmd_rd = 2'd0; cmd_rs1 = 2'd0; cmd_rs2 = 2'd0; cmd_imm = 8'h00;
    for (int i = 0; i < 4; i++) mr[i] = 8'h00;
    mf = 4'h0;
    @(negedge clk); @(negedge clk);
    check("reset_outputs", {cmd_ready, rsp_valid, rsp_result, rsp_flags},
          {1'b1, 1'b0, 8'h00, 4'h0});
    check("reset_alu", {alu_a, alu_b, 5'd0, alu_op}, 32'd0);
    rst = 1'b0;

    // Subtract equal values gives zero
    run_cmd(3'd6, 2'd0, 2'd0, 2'd0, 8'h01, 0);
    run_cmd(3'd6, 2'd1, 2'd0, 2'd0, 8'h01, 0);
    run_cmd(3'd1, 2'd2, 2'd0, 2'd1, 8'h00, 0);
    check("t1_result", last_res, 8'h00);
    check("t1_zero", last_flags[0], 1);
    run_cmd(3'd3, 2'd3, 2'd2, 2'd2, 8'h00, 0);
    check("t1_r2", last_res, 8'h00);

    // Add without and with carry-out
    run_cmd(3'd6, 2'd0, 2'd0, 2'd0, 8'h80, 0);
    run_cmd(3'd0, 2'd3, 2'd0, 2'd1, 8'h00, 0);
    check("t2_add", {last_res, last_flags[2:1]}, {8'h81, 2'b00});
    run_cmd(3'd6, 2'd0, 2'd0, 2'd0, 8'hFF, 0);
    run_cmd(3'd0, 2'd3, 2'd0, 2'd1, 8'h00, 0);
    check("t2_wrap", {last_res, last_flags[1:0]}, {8'h00, 2'b11});

    // Compare writes flags only
    run_cmd(3'd6, 2'd2, 2'd0, 2'd0, 8'hAA, 0);
    run_cmd(3'd6, 2'd0, 2'd0, 2'd0, 8'h05, 0);
    run_cmd(3'd6, 2'd1, 2'd0, 2'd0, 8'h05, 0);
    run_cmd(3'd5, 2'd2, 2'd0, 2'd1, 8'h00, 0);
    check("t3_cmp_zero", last_flags[0], 1);
    run_cmd(3'd3, 2'd3, 2'd2, 2'd2, 8'h00, 0);
    check("t3_r2_kept", last_res, 8'hAA);

    // rd aliasing source, nop, and back-pressure on the response
    run_cmd(3'd0, 2'd0, 2'd0, 2'd0, 8'h00, 4);
    run_cmd(3'd7, 2'd1, 2'd0, 2'd0, 8'h33, 4);
    check("nop_result", last_res, 8'h00);

    // Random commands against the model
    for (int n = 0; n < 60; n++) begin
      run_cmd(3'($urandom_range(0, 7)), 2'($urandom), 2'($urandom), 2'($urandom),
              8'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    // Reset in the middle of an ALU command
    run_cmd(3'd6, 2'd1, 2'd0, 2'd0, 8'h5A, 0);
    @(negedge clk);
    cmd_op = 3'd0; cmd_rd = 2'd2; cmd_rs1 = 2'd1; cmd_rs2 = 2'd1; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("t6_in_issue", {rsp_valid, cmd_ready}, 2'b00);
    rst = 1'b1;
    #1;
    check("t6_async_reset", {cmd_ready, rsp_valid, rsp_result, rsp_flags},
          {1'b1, 1'b0, 8'h00, 4'h0});
    check("t6_alu_reset", {alu_a, alu_b, 5'd0, alu_op}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) mr[i] = 8'h00;
    mf = 4'h0;
    quiet = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      quiet &= (rsp_valid === 1'b0) && (cmd_ready === 1'b1);
    end
    check("t6_no_response", quiet, 1);
    for (int i = 0; i < 4; i++) begin
      run_cmd(3'd3, 2'(i), 2'(i), 2'(i), 8'h00, 0);
      check("t6_reg_cleared", last_res, 8'h00);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
